// File: rtl/app_instr_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : app_instr_unpacker_pkg
// Description : Shared constants, state encodings and the word-select helper
//               for the host-to-receiver instruction unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
package app_instr_unpacker_pkg;

    localparam int c_words_per_beat = 4;
    localparam int c_instr_w        = 32;
    localparam int c_rx_data_w      = c_instr_w * c_words_per_beat;
    localparam int c_nwords_w       = 2;
    localparam int c_stall_w        = 16;

    // Host stall limit: rx_valid held against a full FIFO this long is an error.
    localparam logic [c_stall_w-1:0] c_stall_timeout = 16'hFFFF;

    // Unpack FSM encoding
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_send  = 1'b1;

    // Select 32-bit word idx of a beat; word 0 lives in bits [31:0].
    function automatic logic [c_instr_w-1:0] beat_word(
        input logic [c_rx_data_w-1:0] beat,
        input logic [c_nwords_w-1:0]  idx
    );
        return beat[idx*c_instr_w +: c_instr_w];
    endfunction

endpackage
`default_nettype wire

// File: rtl/app_instr_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module      : app_instr_unpacker_if
// Description : Host RX beat channel plus app_en/app_ack word channel.
//               master = host/receiver side, slave = unpacker.
//   rx_valid/rx_ready/rx_data/rx_last/rx_nwords : 128-bit beat handshake
//   app_en/app_ack/app_instr                    : 32-bit word handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface app_instr_unpacker_if;
    import app_instr_unpacker_pkg::*;

    logic                   rx_valid;
    logic                   rx_ready;
    logic [c_rx_data_w-1:0] rx_data;
    logic                   rx_last;
    logic [c_nwords_w-1:0]  rx_nwords;
    logic                   app_en;
    logic                   app_ack;
    logic [c_instr_w-1:0]   app_instr;

    modport master (
        output rx_valid, rx_data, rx_last, rx_nwords, app_ack,
        input  rx_ready, app_en, app_instr
    );

    modport slave (
        input  rx_valid, rx_data, rx_last, rx_nwords, app_ack,
        output rx_ready, app_en, app_instr
    );

endinterface
`default_nettype wire

// File: rtl/app_instr_unpacker_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : app_instr_unpacker_beat_fifo
// Description : Synchronous beat FIFO with registered ready (not-full) flag,
//               empty flag, occupancy and head entry taken straight from the
//               storage registers.
//   i_push/i_data : write request (ignored while o_ready is low)
//   i_pop         : release head entry (ignored while empty)
//   o_head        : oldest entry
//   o_count       : occupancy, o_empty : no entries, o_ready : room for a push
// Revision    : 1.0 - initial release
// ============================================================================
module app_instr_unpacker_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 131
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_head,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_empty,
    output logic                          o_ready
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_ready;

    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count_nxt;

    // Push is judged against the fullness at the start of the cycle, so a
    // simultaneous push and pop on a full FIFO only pops.
    assign w_push      = i_push & r_ready;
    assign w_pop       = i_pop & (r_count != '0);
    assign w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_nxt;
            // Ready is precomputed from the next occupancy so it stays a
            // flop output with no path from rx_valid.
            r_ready <= (w_count_nxt != c_cnt_w'(DEPTH));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/app_instr_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : app_instr_unpacker
// Description : Buffers 128-bit host beats and serialises them into 32-bit
//               app_instr words (word 0 first), honouring partial last beats.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : rx beat channel in, app word channel out
//   xfer_done     : pulse after the last word of a transfer is accepted
//   word_count    : words accepted since reset (wraps)
//   xfer_count    : transfers completed since reset (wraps)
//   overflow_err  : sticky host stall timeout
// Revision    : 1.0 - initial release
// ============================================================================
module app_instr_unpacker
    import app_instr_unpacker_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int WORDS_PER_BEAT = c_words_per_beat   // fixed at 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    app_instr_unpacker_if.slave   bus,
    output logic                  xfer_done,
    output logic [31:0]           word_count,
    output logic [15:0]           xfer_count,
    output logic                  overflow_err
);

    localparam int c_beat_w  = c_instr_w * WORDS_PER_BEAT;
    localparam int c_entry_w = c_beat_w + 1 + c_nwords_w;
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH) + 1;

    logic [c_entry_w-1:0]  w_push_entry;
    logic [c_entry_w-1:0]  w_head;
    logic [c_cnt_w-1:0]    w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_fifo_ready;
    logic [c_beat_w-1:0]   w_head_data;
    logic                  w_head_last;
    logic [c_nwords_w-1:0] w_head_nwords;
    logic                  w_ack;
    logic                  w_last_word;
    logic                  w_pop;

    logic [0:0]            r_state;
    logic [c_nwords_w-1:0] r_idx;
    logic                  r_xfer_done;
    logic [31:0]           r_word_count;
    logic [15:0]           r_xfer_count;
    logic [c_stall_w-1:0]  r_stall;
    logic                  r_overflow;

    // Entry layout {data, last, nwords}; non-last beats always carry 4 words.
    assign w_push_entry = {bus.rx_data, bus.rx_last,
                           bus.rx_last ? bus.rx_nwords : c_nwords_w'(3)};

    app_instr_unpacker_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_entry_w)
    ) u_beat_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.rx_valid),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_ready (w_fifo_ready)
    );

    assign w_head_data   = w_head[c_entry_w-1 -: c_beat_w];
    assign w_head_last   = w_head[c_nwords_w];
    assign w_head_nwords = w_head[c_nwords_w-1:0];

    assign w_ack       = (r_state == c_st_send) & bus.app_ack;
    assign w_last_word = (r_idx == w_head_nwords);
    assign w_pop       = w_ack & w_last_word;

    // app_en/app_instr come only from the state register, idx and the FIFO
    // head, so a receiver may derive app_ack from app_en without a loop.
    assign bus.rx_ready  = w_fifo_ready;
    assign bus.app_en    = (r_state == c_st_send);
    assign bus.app_instr = (r_state == c_st_send) ? beat_word(w_head_data, r_idx)
                                                  : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_empty;
            r_idx        <= '0;
            r_xfer_done  <= 1'b0;
            r_word_count <= '0;
            r_xfer_count <= '0;
            r_stall      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_xfer_done <= w_pop & w_head_last;

            if (r_xfer_done) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
            if (w_ack) begin
                r_word_count <= r_word_count + 32'd1;
            end

            case (r_state)
                c_st_empty: begin
                    r_idx <= '0;
                    if (!w_fifo_empty) begin
                        r_state <= c_st_send;
                    end
                end
                c_st_send: begin
                    if (w_ack) begin
                        if (w_last_word) begin
                            r_idx <= '0;
                            // Another beat behind the head: continue with no bubble.
                            r_state <= (w_fifo_count > c_cnt_w'(1)) ? c_st_send
                                                                    : c_st_empty;
                        end else begin
                            r_idx <= r_idx + c_nwords_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_st_empty;
                    r_idx   <= '0;
                end
            endcase

            // Stall counter saturates at the timeout; the error is flagged
            // once the counter sits at the timeout value.
            if (bus.rx_valid & ~w_fifo_ready) begin
                if (r_stall != c_stall_timeout) begin
                    r_stall <= r_stall + c_stall_w'(1);
                end
            end else begin
                r_stall <= '0;
            end
            if (r_stall == c_stall_timeout) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign xfer_done    = r_xfer_done;
    assign word_count   = r_word_count;
    assign xfer_count   = r_xfer_count;
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_app_instr_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_app_instr_unpacker
// Description : Directed self-checking bench for app_instr_unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_app_instr_unpacker;

    logic        clk;
    logic        rst;
    logic        xfer_done;
    logic [31:0] word_count;
    logic [15:0] xfer_count;
    logic        overflow_err;

    int n_checks;
    int n_fail;
    int cyc;

    logic [31:0] wq[$];
    int          ws[$];
    int          done_cnt;
    int          done_stamp;

    app_instr_unpacker_if u_if ();

    app_instr_unpacker #(
        .FIFO_DEPTH     (4),
        .WORDS_PER_BEAT (4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (u_if),
        .xfer_done    (xfer_done),
        .word_count   (word_count),
        .xfer_count   (xfer_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Words that will transfer on the coming rising edge, and xfer_done pulses.
    always @(negedge clk) begin
        if (!rst && u_if.app_en && u_if.app_ack) begin
            wq.push_back(u_if.app_instr);
            ws.push_back(cyc);
        end
        if (xfer_done) begin
            done_cnt   = done_cnt + 1;
            done_stamp = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_beat(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic last, input logic [1:0] nw);
        logic took;
        int   n;
        took = 1'b0;
        n    = 0;
        u_if.rx_valid  = 1'b1;
        u_if.rx_data   = d;
        u_if.rx_last   = last;
        u_if.rx_nwords = nw;
        while (!took && n < 200) begin
            @(negedge clk);
            took = u_if.rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        u_if.rx_valid = 1'b0;
        if (!took) check("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        wq.delete();
        ws.delete();
        done_cnt = 0;
    endtask

    initial begin
        int bad;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        done_cnt = 0;
        done_stamp = 0;
        rst            = 1'b1;
        u_if.rx_valid  = 1'b0;
        u_if.rx_data   = '0;
        u_if.rx_last   = 1'b0;
        u_if.rx_nwords = '0;
        u_if.app_ack   = 1'b0;

        // Reset state
        idle(2);
        check("rst_rx_ready", {31'd0, u_if.rx_ready}, 32'd0);
        check("rst_app_en", {31'd0, u_if.app_en}, 32'd0);
        check("rst_app_instr", u_if.app_instr, 32'd0);
        check("rst_word_count", word_count, 32'd0);
        check("rst_overflow", {31'd0, overflow_err}, 32'd0);
        rst = 1'b0;
        idle(1);
        check("post_rst_rx_ready", {31'd0, u_if.rx_ready}, 32'd1);

        // 1: single non-last beat; nwords must be ignored
        clear_log();
        u_if.app_ack = 1'b1;
        send_beat(mk_beat(32'h0), 1'b0, 2'd1);
        idle(8);
        check("t1_nwords", wq.size(), 32'd4);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) if (wq[i] != 32'(i)) bad++;
        check("t1_order", bad, 32'd0);
        if (ws.size() == 4) check("t1_span", ws[3] - ws[0], 32'd3);
        check("t1_word_count", word_count, 32'd4);
        check("t1_no_done", done_cnt, 32'd0);

        // 2: two beats back to back, second partial last (2 words)
        clear_log();
        send_beat(mk_beat(32'h10), 1'b0, 2'd0);
        send_beat({32'hDEAD, 32'hBEEF, 32'hA1, 32'hA0}, 1'b1, 2'd1);
        idle(10);
        check("t2_nwords", wq.size(), 32'd6);
        if (wq.size() == 6) begin
            check("t2_w0", wq[0], 32'h10);
            check("t2_w3", wq[3], 32'h13);
            check("t2_w4", wq[4], 32'hA0);
            check("t2_w5", wq[5], 32'hA1);
            check("t2_span", ws[5] - ws[0], 32'd5);
        end
        check("t2_done_cnt", done_cnt, 32'd1);
        check("t2_xfer_count", xfer_count, 32'd1);
        check("t2_word_count", word_count, 32'd10);

        // 3: receiver stall, FIFO fills, drain order preserved
        clear_log();
        u_if.app_ack = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(mk_beat(32'h3000 + 32'(k) * 32'h10), 1'b0, 2'd0);
        check("t3_full_ready", {31'd0, u_if.rx_ready}, 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            if (!u_if.app_en || u_if.app_instr != 32'h3000) bad++;
        end
        check("t3_hold_stable", bad, 32'd0);
        check("t3_hold_word", u_if.app_instr, 32'h3000);
        u_if.app_ack = 1'b1;
        idle(25);
        check("t3_nwords", wq.size(), 32'd16);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] != 32'h3000 + 32'(i / 4) * 32'h10 + 32'(i % 4)) bad++;
        check("t3_drain_order", bad, 32'd0);
        check("t3_ready_back", {31'd0, u_if.rx_ready}, 32'd1);
        check("t3_word_count", word_count, 32'd26);

        // 4: last beat with nwords=0 emits only word0
        clear_log();
        send_beat({32'h33, 32'h22, 32'h11, 32'hF000_0000}, 1'b1, 2'd0);
        idle(8);
        check("t4_nwords", wq.size(), 32'd1);
        if (wq.size() == 1) begin
            check("t4_word", wq[0], 32'hF000_0000);
            check("t4_done_delay", done_stamp - ws[0], 32'd1);
        end
        check("t4_done_cnt", done_cnt, 32'd1);
        check("t4_xfer_count", xfer_count, 32'd2);
        check("t4_word_count", word_count, 32'd27);

        // 5: reset with beats buffered and idx=2
        u_if.app_ack = 1'b0;
        send_beat(mk_beat(32'h50), 1'b0, 2'd0);
        send_beat(mk_beat(32'h60), 1'b0, 2'd0);
        send_beat(mk_beat(32'h70), 1'b1, 2'd3);
        u_if.app_ack = 1'b1;
        idle(2);
        check("t5_pre_rst_word", u_if.app_instr, 32'h52);
        u_if.app_ack = 1'b0;
        rst = 1'b1;
        idle(1);
        check("t5_app_en", {31'd0, u_if.app_en}, 32'd0);
        check("t5_app_instr", u_if.app_instr, 32'd0);
        check("t5_word_count", word_count, 32'd0);
        check("t5_xfer_count", {16'd0, xfer_count}, 32'd0);
        rst = 1'b0;
        idle(3);
        check("t5_idle_app_en", {31'd0, u_if.app_en}, 32'd0);
        clear_log();
        u_if.app_ack = 1'b1;
        send_beat(mk_beat(32'h80), 1'b0, 2'd0);
        idle(8);
        check("t5_nwords", wq.size(), 32'd4);
        if (wq.size() == 4) check("t5_first", wq[0], 32'h80);

        // 6: host stall timeout, sticky until reset
        clear_log();
        u_if.app_ack = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(mk_beat(32'h9000 + 32'(k) * 32'h10), 1'b0, 2'd0);
        u_if.rx_valid = 1'b1;
        u_if.rx_data  = mk_beat(32'h9040);
        u_if.rx_last  = 1'b0;
        idle(65000);
        check("t6_no_early_ovf", {31'd0, overflow_err}, 32'd0);
        idle(1000);
        check("t6_ovf_set", {31'd0, overflow_err}, 32'd1);
        u_if.app_ack = 1'b1;
        send_beat(mk_beat(32'h9040), 1'b0, 2'd0);
        idle(30);
        check("t6_nwords", wq.size(), 32'd20);
        check("t6_ovf_sticky", {31'd0, overflow_err}, 32'd1);
        rst = 1'b1;
        idle(1);
        check("t6_ovf_cleared", {31'd0, overflow_err}, 32'd0);
        rst = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
